// File: rtl/itof_if.sv
// Operand/result channel of the integer-to-binary32 pipeline.
// Handshake: a word moves when valid & ready are both high on a rising clk edge; a source
// holds its payload and valid steady until that happens, and ready may depend on state only.
interface itof_if #(
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_signed;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic                 out_inexact;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_inexact, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_inexact, out_tag
  );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 binary32 converter (round-to-nearest-even, inexact flag).
// Stages: sign/magnitude, normalise, round/pack; all stages shift together under one advance.
module itof_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 6
) (
  input logic   clk,
  input logic   rst,
  itof_if.slave bus
);
  localparam int PW = $clog2(IN_WIDTH);
  // Bits below the leading one, padded so IN_WIDTH < 25 still yields 23 frac bits + guard.
  localparam int EW = IN_WIDTH + 23;

  logic advance;

  // stage 1: sign and magnitude
  logic                 s1_valid;
  logic                 s1_sign;
  logic [IN_WIDTH-1:0]  s1_mag;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 in_sign;
  logic [IN_WIDTH-1:0]  in_mag;

  // stage 2: normalised magnitude with the leading one stripped
  logic                 s2_valid;
  logic                 s2_sign;
  logic                 s2_zero;
  logic [PW-1:0]        s2_p;
  logic [IN_WIDTH-2:0]  s2_below;
  logic [TAG_WIDTH-1:0] s2_tag;
  logic [PW-1:0]        lead_p;
  logic [IN_WIDTH-1:0]  shifted;

  // stage 3: round and pack into the output registers
  logic                 out_valid_q;
  logic [31:0]          out_data_q;
  logic                 out_inexact_q;
  logic [TAG_WIDTH-1:0] out_tag_q;
  logic [EW-1:0]        ext;
  logic [22:0]          frac;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [30:0]          exp_frac;
  logic [31:0]          res_data;
  logic                 res_inexact;

  assign advance      = !out_valid_q | bus.out_ready;
  assign bus.in_ready = advance;

  assign in_sign = bus.in_signed & bus.in_data[IN_WIDTH-1];
  assign in_mag  = in_sign ? (~bus.in_data) + IN_WIDTH'(1) : bus.in_data;

  always_comb begin
    lead_p = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag[i]) lead_p = PW'(i);
    end
  end

  // After the shift the MSB is set exactly when the magnitude is nonzero.
  assign shifted = s1_mag << (PW'(IN_WIDTH - 1) - lead_p);

  always_comb begin
    ext         = {s2_below, 24'd0};
    frac        = ext[EW-1 -: 23];
    guard       = ext[EW-24];
    sticky      = |ext[EW-25:0];
    round_up    = guard & (sticky | frac[0]);
    // A carry out of frac lands in the exponent field, which is the mantissa-overflow case.
    exp_frac    = {8'd127 + 8'(s2_p), frac} + 31'(round_up);
    res_data    = s2_zero ? 32'd0 : {s2_sign, exp_frac};
    res_inexact = !s2_zero & (guard | sticky);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
      out_tag_q     <= '0;
    end else if (advance) begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_data_q    <= res_data;
        out_inexact_q <= res_inexact;
        out_tag_q     <= s2_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign  <= in_sign;
      s1_mag   <= in_mag;
      s1_tag   <= bus.in_tag;
      s2_sign  <= s1_sign;
      s2_zero  <= ~shifted[IN_WIDTH-1];
      s2_p     <= lead_p;
      s2_below <= shifted[IN_WIDTH-2:0];
      s2_tag   <= s1_tag;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_inexact = out_inexact_q;
  assign bus.out_tag     = out_tag_q;
endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed conversions, backpressure, reset flush and random traffic
// checked against an arithmetic rounding model through an expected-result queue.
module tb_itof_pipe;
  localparam int W  = 32;
  localparam int TW = 6;
  localparam int RW = TW + 33;   // {tag, inexact, data}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  itof_if #(.IN_WIDTH(W), .TAG_WIDTH(TW)) bus ();

  itof_pipe #(.IN_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic          held_v = 1'b0;
  logic [RW-1:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: round by quotient/remainder against the dropped power of two.
  function automatic logic [32:0] ref_conv(input logic [W-1:0] d, input logic sgn);
    logic neg;
    longint unsigned mag, q, rem, half;
    int p, sh;
    logic up, inx;
    neg = sgn && d[W-1];
    mag = 64'(d);
    if (neg) mag = (64'(1) << W) - mag;
    if (mag == 0) return 33'd0;
    p = 63;
    while (!mag[p]) p--;
    if (p <= 23) return {1'b0, neg, 8'(127 + p), 23'(mag << (23 - p))};
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag - (q << sh);
    half = 64'(1) << (sh - 1);
    up   = (rem > half) || (rem == half && q[0]);
    inx  = (rem != 0);
    q    = q + 64'(up);
    if (q == (64'(1) << 24)) begin
      q = q >> 1;
      p++;
    end
    return {inx, neg, 8'(127 + p), q[22:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      2:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Scoreboard: push accepted operands, pop on output transfers, watch stability while stalled.
  always @(negedge clk) begin
    logic [RW-1:0] cur;
    cur = {bus.out_tag, bus.out_inexact, bus.out_data};
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (held_v) check("stable_while_stalled", 64'(cur), 64'(held));
        if (bus.out_ready) begin
          n_out++;
          if (exp_q.size() == 0) check("unexpected_output", 64'(1), 64'(0));
          else check("result", 64'(cur), 64'(exp_q.pop_front()));
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = cur;
        end
      end else begin
        held_v = 1'b0;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_tag, ref_conv(bus.in_data, bus.in_signed)});
    end
  end

  // Present one operand and return #1 after the edge that accepted it; in_valid stays high.
  task automatic send(input logic [W-1:0] d, input logic sg, input logic [TW-1:0] t);
    int budget;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = sg;
    bus.in_tag    = t;
    budget = 0;
    @(negedge clk);
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) check("send_timeout", 64'(1), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string nm, input logic [W-1:0] d, input logic sg,
                         input logic [31:0] ed, input logic ei);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = sg;
    bus.in_tag    = TW'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < 10);
    check({nm, "_latency"}, 64'(lat), 64'(3));
    check({nm, "_data"}, 64'(bus.out_data), 64'(ed));
    check({nm, "_inexact"}, 64'(bus.out_inexact), 64'(ei));
  endtask

  task automatic drain(input string nm);
    int budget;
    budget = 0;
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && budget < 500) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check(nm, 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = W'($urandom_range(0, 300));
      1:       v = (W'(1) << $urandom_range(0, W - 1)) + W'($urandom_range(0, 2)) - W'(1);
      2:       v = ~W'($urandom_range(0, 300));
      3:       v = {1'b1, W'(0)} >> $urandom_range(1, W);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int out_before;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.in_tag    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_out_data", 64'(bus.out_data), 64'(0));
    check("reset_out_inexact", 64'(bus.out_inexact), 64'(0));
    check("reset_out_tag", 64'(bus.out_tag), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));

    run_one("one_u", 32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0);
    run_one("minus1_s", 32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0);
    run_one("minneg_s", 32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0);
    run_one("minneg_u", 32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0);
    run_one("zero", 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
    run_one("tie_even", 32'd16777217, 1'b0, 32'h4B80_0000, 1'b1);
    run_one("tie_up", 32'd16777219, 1'b0, 32'h4B80_0002, 1'b1);
    run_one("carry_exp", 32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 1'b1);
    run_one("max_u", 32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1);
    drain("directed_drain");

    // Backpressure: 10 tagged ops with the consumer stalled mid-stream.
    out_before = n_out;
    for (int i = 0; i < 5; i++) send(rand_operand(), 1'($urandom), TW'(i));
    rdy_mode = 2;
    fork
      for (int i = 5; i < 10; i++) send(rand_operand(), 1'($urandom), TW'(i));
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain("bp_drain");
    check("bp_count", 64'(n_out - out_before), 64'(10));

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) send(rand_operand(), 1'($urandom), TW'(20 + i));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'(0));
    check("flush_in_ready", 64'(bus.in_ready), 64'(1));
    check("flush_out_data", 64'(bus.out_data), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_stale", 64'(bus.out_valid), 64'(0));

    // Random traffic with random backpressure and input gaps.
    rdy_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rand_operand(), 1'($urandom), TW'($urandom));
    end
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
